// File: rtl/mc_cu.sv
// Multi-cycle control unit for the MIPS-subset CPU: decodes op/func and steps each
// instruction through IF/ID/EXE/MEM/WB, stalling IF and MEM for MEM_LAT cycles.
module mc_cu #(
  parameter int unsigned MEM_LAT = 1,
  parameter int unsigned CNT_W   = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] func,
  input  logic       z,
  output logic       wpc,
  output logic       wir,
  output logic       wmem,
  output logic       wreg,
  output logic       iord,
  output logic       regrt,
  output logic       m2reg,
  output logic       jal,
  output logic       shift,
  output logic       sext,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [3:0] aluc,
  output logic [1:0] pcsource,
  output logic       illegal,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    StIf  = 3'd0,
    StId  = 3'd1,
    StExe = 3'd2,
    StMem = 3'd3,
    StWb  = 3'd4
  } state_e;

  state_e           st_q, st_d;
  logic [CNT_W-1:0] cnt_q;
  logic             last;

  logic rtype;
  logic i_add, i_sub, i_and, i_or, i_xor, i_sll, i_srl, i_sra, i_jr;
  logic i_addi, i_andi, i_ori, i_xori, i_lui, i_lw, i_sw, i_beq, i_bne, i_j, i_jal;
  logic r_alu, r_shift, i_alu, branch, legal;
  logic [3:0] alu_op;

  assign rtype   = (op == 6'b000000);
  assign i_add   = rtype & (func == 6'b100000);
  assign i_sub   = rtype & (func == 6'b100010);
  assign i_and   = rtype & (func == 6'b100100);
  assign i_or    = rtype & (func == 6'b100101);
  assign i_xor   = rtype & (func == 6'b100110);
  assign i_sll   = rtype & (func == 6'b000000);
  assign i_srl   = rtype & (func == 6'b000010);
  assign i_sra   = rtype & (func == 6'b000011);
  assign i_jr    = rtype & (func == 6'b001000);
  assign i_addi  = (op == 6'b001000);
  assign i_andi  = (op == 6'b001100);
  assign i_ori   = (op == 6'b001101);
  assign i_xori  = (op == 6'b001110);
  assign i_lui   = (op == 6'b001111);
  assign i_lw    = (op == 6'b100011);
  assign i_sw    = (op == 6'b101011);
  assign i_beq   = (op == 6'b000100);
  assign i_bne   = (op == 6'b000101);
  assign i_j     = (op == 6'b000010);
  assign i_jal   = (op == 6'b000011);

  assign r_alu   = i_add | i_sub | i_and | i_or | i_xor;
  assign r_shift = i_sll | i_srl | i_sra;
  assign i_alu   = i_addi | i_andi | i_ori | i_xori | i_lui;
  assign branch  = i_beq | i_bne;
  assign legal   = r_alu | r_shift | i_jr | i_alu | i_lw | i_sw | branch | i_j | i_jal;

  assign last    = (cnt_q == CNT_W'(MEM_LAT - 1));
  assign state   = st_q;

  always_comb begin
    alu_op = 4'b0000;
    if (i_sub)               alu_op = 4'b0100;
    else if (i_and | i_andi) alu_op = 4'b0001;
    else if (i_or | i_ori)   alu_op = 4'b0101;
    else if (i_xor | i_xori) alu_op = 4'b0010;
    else if (i_lui)          alu_op = 4'b0110;
    else if (i_sll)          alu_op = 4'b0011;
    else if (i_srl)          alu_op = 4'b0111;
    else if (i_sra)          alu_op = 4'b1111;
  end

  always_comb begin
    st_d = StIf;
    case (st_q)
      StIf:  st_d = last ? StId : StIf;
      StId:  st_d = (i_j | i_jal | i_jr | !legal) ? StIf : StExe;
      StExe: begin
        if (branch)            st_d = StIf;
        else if (i_lw | i_sw)  st_d = StMem;
        else                   st_d = StWb;
      end
      StMem: st_d = !last ? StMem : (i_lw ? StWb : StIf);
      StWb:  st_d = StIf;
      default: st_d = StIf;
    endcase
  end

  // The wait counter restarts on every state change so each IF/MEM visit waits afresh.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      st_q  <= StIf;
      cnt_q <= '0;
    end else begin
      st_q <= st_d;
      if (st_d != st_q) begin
        cnt_q <= '0;
      end else if ((st_q == StIf || st_q == StMem) && !last) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  always_comb begin
    wpc      = 1'b0;
    wir      = 1'b0;
    wmem     = 1'b0;
    wreg     = 1'b0;
    iord     = 1'b0;
    regrt    = 1'b0;
    m2reg    = 1'b0;
    jal      = 1'b0;
    shift    = 1'b0;
    sext     = 1'b0;
    alusrca  = 1'b0;
    alusrcb  = 2'b00;
    aluc     = 4'b0000;
    pcsource = 2'b00;
    illegal  = 1'b0;
    case (st_q)
      StIf: begin
        alusrcb = 2'b01;
        wir     = last;
        wpc     = last;
      end
      StId: begin
        if (i_j | i_jal) begin
          wpc      = 1'b1;
          pcsource = 2'b11;
          wreg     = i_jal;
          jal      = i_jal;
        end else if (i_jr) begin
          wpc      = 1'b1;
          pcsource = 2'b10;
        end else if (!legal) begin
          illegal = 1'b1;
        end else begin
          // Precompute the branch target into ALUOut.
          alusrcb = 2'b11;
          sext    = 1'b1;
        end
      end
      StExe: begin
        alusrca = 1'b1;
        if (branch) begin
          aluc     = 4'b0100;
          pcsource = 2'b01;
          wpc      = (i_beq & z) | (i_bne & ~z);
        end else if (r_alu | r_shift) begin
          aluc  = alu_op;
          shift = r_shift;
        end else begin
          alusrcb = 2'b10;
          regrt   = 1'b1;
          aluc    = alu_op;
          sext    = i_addi | i_lw | i_sw;
        end
      end
      StMem: begin
        iord = 1'b1;
        wmem = i_sw & last;
      end
      StWb: begin
        wreg  = 1'b1;
        m2reg = i_lw;
        regrt = i_alu | i_lw;
      end
      default: ;
    endcase
    if (reset) begin
      wpc     = 1'b0;
      wir     = 1'b0;
      wmem    = 1'b0;
      wreg    = 1'b0;
      illegal = 1'b0;
    end
  end

endmodule

// File: tb/tb_mc_cu.sv
// Scoreboard bench for mc_cu: three instances (MEM_LAT 1, 3, 4) each get directed and
// random instructions; a per-cycle trace model fills a queue that a monitor drains.
module tb_mc_cu;

  typedef struct packed {
    logic       wpc, wir, wmem, wreg, iord, regrt, m2reg, jal, shift, sext, alusrca;
    logic [1:0] alusrcb;
    logic [3:0] aluc;
    logic [1:0] pcsource;
    logic       illegal;
    logic [2:0] state;
  } ctl_t;

  localparam int K_R = 0, K_SH = 1, K_JR = 2, K_I = 3, K_LW = 4, K_SW = 5;
  localparam int K_BEQ = 6, K_BNE = 7, K_J = 8, K_JAL = 9, K_ILL = 10;

  localparam logic [11:0] LEGAL [20] = '{
    {6'b000000, 6'b100000}, {6'b000000, 6'b100010}, {6'b000000, 6'b100100},
    {6'b000000, 6'b100101}, {6'b000000, 6'b100110}, {6'b000000, 6'b000000},
    {6'b000000, 6'b000010}, {6'b000000, 6'b000011}, {6'b000000, 6'b001000},
    {6'b001000, 6'b000000}, {6'b001100, 6'b000000}, {6'b001101, 6'b000000},
    {6'b001110, 6'b000000}, {6'b100011, 6'b000000}, {6'b101011, 6'b000000},
    {6'b000100, 6'b000000}, {6'b000101, 6'b000000}, {6'b001111, 6'b000000},
    {6'b000010, 6'b000000}, {6'b000011, 6'b000000}
  };

  logic clock;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   done_cnt = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Instruction class, ALU code and extension mode straight from the instruction table.
  function automatic void classify(input logic [5:0] o, input logic [5:0] f,
                                   output int k, output logic [3:0] a, output logic se);
    k = K_ILL; a = 4'b0000; se = 1'b0;
    case (o)
      6'b000000: case (f)
        6'b100000: k = K_R;
        6'b100010: begin k = K_R; a = 4'b0100; end
        6'b100100: begin k = K_R; a = 4'b0001; end
        6'b100101: begin k = K_R; a = 4'b0101; end
        6'b100110: begin k = K_R; a = 4'b0010; end
        6'b000000: begin k = K_SH; a = 4'b0011; end
        6'b000010: begin k = K_SH; a = 4'b0111; end
        6'b000011: begin k = K_SH; a = 4'b1111; end
        6'b001000: k = K_JR;
        default:   k = K_ILL;
      endcase
      6'b001000: begin k = K_I; se = 1'b1; end
      6'b001100: begin k = K_I; a = 4'b0001; end
      6'b001101: begin k = K_I; a = 4'b0101; end
      6'b001110: begin k = K_I; a = 4'b0010; end
      6'b001111: begin k = K_I; a = 4'b0110; end
      6'b100011: begin k = K_LW; se = 1'b1; end
      6'b101011: begin k = K_SW; se = 1'b1; end
      6'b000100: k = K_BEQ;
      6'b000101: k = K_BNE;
      6'b000010: k = K_J;
      6'b000011: k = K_JAL;
      default:   k = K_ILL;
    endcase
  endfunction

  function automatic ctl_t blank(input logic [2:0] s);
    ctl_t c;
    c = '0;
    c.state = s;
    return c;
  endfunction

  for (genvar gi = 0; gi < 3; gi++) begin : g_inst
    localparam int unsigned L = (gi == 0) ? 1 : ((gi == 1) ? 3 : 4);

    logic       rst, z;
    logic [5:0] op, func;
    logic       wpc, wir, wmem, wreg, iord, regrt, m2reg, jal, shift, sext, alusrca, illegal;
    logic [1:0] alusrcb, pcsource;
    logic [3:0] aluc;
    logic [2:0] state;
    ctl_t       act;
    ctl_t       exp_q[$];
    ctl_t       seq[$];

    mc_cu #(.MEM_LAT(L), .CNT_W(4)) dut (
      .clock(clock), .reset(rst), .op(op), .func(func), .z(z),
      .wpc(wpc), .wir(wir), .wmem(wmem), .wreg(wreg), .iord(iord), .regrt(regrt),
      .m2reg(m2reg), .jal(jal), .shift(shift), .sext(sext), .alusrca(alusrca),
      .alusrcb(alusrcb), .aluc(aluc), .pcsource(pcsource), .illegal(illegal),
      .state(state)
    );

    assign act = {wpc, wir, wmem, wreg, iord, regrt, m2reg, jal, shift, sext, alusrca,
                  alusrcb, aluc, pcsource, illegal, state};

    // Full cycle-by-cycle trace of one instruction into seq.
    function automatic void build(input logic [5:0] o, input logic [5:0] f, input logic zz);
      int k; logic [3:0] a; logic se; ctl_t c;
      classify(o, f, k, a, se);
      for (int i = 0; i < int'(L); i++) begin
        c = blank(3'd0); c.alusrcb = 2'b01;
        c.wir = (i == int'(L) - 1); c.wpc = c.wir;
        seq.push_back(c);
      end
      c = blank(3'd1);
      case (k)
        K_J:     begin c.wpc = 1'b1; c.pcsource = 2'b11; end
        K_JAL:   begin c.wpc = 1'b1; c.pcsource = 2'b11; c.wreg = 1'b1; c.jal = 1'b1; end
        K_JR:    begin c.wpc = 1'b1; c.pcsource = 2'b10; end
        K_ILL:   c.illegal = 1'b1;
        default: begin c.alusrcb = 2'b11; c.sext = 1'b1; end
      endcase
      seq.push_back(c);
      if (k == K_J || k == K_JAL || k == K_JR || k == K_ILL) return;
      c = blank(3'd2); c.alusrca = 1'b1;
      case (k)
        K_R:  c.aluc = a;
        K_SH: begin c.aluc = a; c.shift = 1'b1; end
        K_BEQ, K_BNE: begin
          c.aluc = 4'b0100; c.pcsource = 2'b01;
          c.wpc = (k == K_BEQ) ? zz : !zz;
        end
        default: begin c.alusrcb = 2'b10; c.regrt = 1'b1; c.aluc = a; c.sext = se; end
      endcase
      seq.push_back(c);
      if (k == K_BEQ || k == K_BNE) return;
      if (k == K_LW || k == K_SW) begin
        for (int i = 0; i < int'(L); i++) begin
          c = blank(3'd3); c.iord = 1'b1;
          c.wmem = (k == K_SW) && (i == int'(L) - 1);
          seq.push_back(c);
        end
      end
      if (k == K_SW) return;
      c = blank(3'd4); c.wreg = 1'b1; c.m2reg = (k == K_LW); c.regrt = (k == K_I || k == K_LW);
      seq.push_back(c);
    endfunction

    // Called at posedge+1; the cycle under reset looks like IF with no write enables.
    task automatic do_reset();
      ctl_t c;
      c = blank(3'd0); c.alusrcb = 2'b01;
      rst = 1'b1;
      exp_q.push_back(c);
      @(posedge clock);
      #1;
      rst = 1'b0;
    endtask

    // abort_at: 0 = run to completion, -1 = random abort, >0 = reset on that cycle index.
    task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input logic zz,
                             input int abort_at);
      int n;
      seq.delete();
      build(o, f, zz);
      n = seq.size();
      if (abort_at < 0) n = int'($urandom_range(1, seq.size() - 1));
      else if (abort_at > 0 && abort_at < n) n = abort_at;
      for (int i = 0; i < n; i++) exp_q.push_back(seq[i]);
      op = o; func = f; z = zz;
      repeat (n) @(posedge clock);
      #1;
      if (n < seq.size()) do_reset();
    endtask

    initial begin
      rst = 1'b1; op = 6'd0; func = 6'd0; z = 1'b0;
      @(posedge clock);
      #1;
      do_reset();
      run_instr(6'b000000, 6'b100000, 1'b0, 0);   // add
      run_instr(6'b100011, 6'b000000, 1'b0, 0);   // lw
      run_instr(6'b000100, 6'b000000, 1'b1, 0);   // beq taken
      run_instr(6'b000100, 6'b000000, 1'b0, 0);   // beq not taken
      run_instr(6'b000101, 6'b000000, 1'b0, 0);   // bne taken
      run_instr(6'b000101, 6'b000000, 1'b1, 0);   // bne not taken
      run_instr(6'b000011, 6'b010101, 1'b0, 0);   // jal
      run_instr(6'b111111, 6'b101010, 1'b0, 0);   // illegal
      run_instr(6'b000000, 6'b111111, 1'b0, 0);   // illegal func
      run_instr(6'b101011, 6'b000000, 1'b0, 0);   // sw complete
      // sw aborted in MEM at cnt=2 (or on the final MEM cycle when MEM_LAT is shorter)
      run_instr(6'b101011, 6'b000000, 1'b0, int'(L) + 2 + ((L > 2) ? 2 : int'(L) - 1));
      run_instr(6'b000000, 6'b100010, 1'b0, 0);   // sub after reset release
      for (int t = 0; t < 150; t++) begin
        logic [11:0] pk; logic [5:0] o, f; int ab;
        if ($urandom_range(0, 9) == 0) begin
          o = 6'($urandom); f = 6'($urandom);
        end else begin
          pk = LEGAL[$urandom_range(0, 19)];
          o = pk[11:6];
          f = (o == 6'd0) ? pk[5:0] : 6'($urandom);
        end
        ab = ($urandom_range(0, 7) == 0) ? -1 : 0;
        run_instr(o, f, 1'($urandom), ab);
      end
      done_cnt++;
    end

    initial begin
      ctl_t e;
      forever begin
        @(negedge clock);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          n_checks++;
          if (act !== e) begin
            n_fail++;
            $display("FAIL ctl_trace lat=%0d t=%0t: got %h (state %0d) required %h (state %0d)",
                     L, $time, act, act.state, e, e.state);
          end
        end
      end
    end
  end

  initial begin
    int cyc;
    cyc = 0;
    while (done_cnt < 3 && cyc < 50000) begin
      @(posedge clock);
      cyc++;
    end
    n_checks++;
    if (done_cnt < 3) begin
      n_fail++;
      $display("FAIL completion: got %0d of 3 streams finished, required 3", done_cnt);
    end
    @(negedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
